// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Brief    : Shared playfield/paddle constants, FSM state type and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam int c_pos_w          = 10;
    localparam int c_screen_w       = 640;
    localparam int c_screen_h       = 480;
    localparam int c_ball_size      = 8;
    localparam int c_paddle_w       = 8;
    localparam int c_paddle_h       = 64;
    localparam int c_left_paddle_x  = 16;
    localparam int c_right_paddle_x = 616;
    localparam int c_speed          = 2;
    localparam int c_serve_delay    = 60;
    localparam int c_win_score      = 9;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_WAIT = 2'd1,
        PLAY       = 2'd2,
        POINT      = 2'd3
    } state_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/paddle_hit_check.sv
`default_nettype none
// ============================================================================
// Module   : paddle_hit_check
// Brief    : Combinational test for the ball crossing a paddle face this frame.
// Revision : 1.0 - initial release
// ============================================================================
module paddle_hit_check
    import pong_pkg::*;
#(
    parameter bit IS_LEFT   = 1'b1,
    parameter int EDGE_X    = 24,
    parameter int BALL_SIZE = 8,
    parameter int PADDLE_H  = 64
) (
    input  logic [c_pos_w-1:0] i_ball_x,
    input  logic [c_pos_w-1:0] i_ball_y,
    input  logic signed [10:0] i_next_x,
    input  logic               i_toward,
    input  logic [c_pos_w-1:0] i_paddle_y,
    output logic               o_hit
);

    localparam logic signed [10:0] c_edge      = 11'(EDGE_X);
    localparam logic        [10:0] c_ball_size = 11'(BALL_SIZE);
    localparam logic        [10:0] c_paddle_h  = 11'(PADDLE_H);

    logic signed [10:0] w_x;
    logic               w_cross;
    logic               w_overlap;

    assign w_x = {1'b0, i_ball_x};

    // The face is hit only when the ball starts on the open side and the step reaches it.
    assign w_cross = IS_LEFT ? ((w_x >= c_edge) && (i_next_x <= c_edge))
                             : ((w_x <= c_edge) && (i_next_x >= c_edge));

    assign w_overlap = (({1'b0, i_ball_y} + c_ball_size) > {1'b0, i_paddle_y}) &&
                       ({1'b0, i_ball_y} < ({1'b0, i_paddle_y} + c_paddle_h));

    assign o_hit = i_toward && w_cross && w_overlap;

endmodule
`default_nettype wire

// File: rtl/ball_engine.sv
`default_nettype none
// ============================================================================
// Module   : ball_engine
// Brief    : Pong ball motion, wall/paddle bounces, scoring and serve sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module ball_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W       = c_screen_w,
    parameter int SCREEN_H       = c_screen_h,
    parameter int BALL_SIZE      = c_ball_size,
    parameter int PADDLE_W       = c_paddle_w,
    parameter int PADDLE_H       = c_paddle_h,
    parameter int LEFT_PADDLE_X  = c_left_paddle_x,
    parameter int RIGHT_PADDLE_X = c_right_paddle_x,
    parameter int SPEED          = c_speed,
    parameter int SERVE_DELAY    = c_serve_delay,
    parameter int WIN_SCORE      = c_win_score
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic [c_pos_w-1:0] player_paddle_y,
    input  logic [c_pos_w-1:0] ai_paddle_y,
    output logic [19:0]        ball_state,
    output logic [3:0]         player_score,
    output logic [3:0]         ai_score,
    output logic               point_player,
    output logic               point_ai,
    output logic               in_play
);

    localparam logic signed [10:0] c_spd        = 11'(SPEED);
    localparam logic signed [10:0] c_x_max      = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] c_y_max      = 11'(SCREEN_H - BALL_SIZE);
    localparam logic signed [10:0] c_left_edge  = 11'(LEFT_PADDLE_X + PADDLE_W);
    localparam logic signed [10:0] c_right_edge = 11'(RIGHT_PADDLE_X - BALL_SIZE);
    localparam logic [c_pos_w-1:0] c_ctr_x      = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [c_pos_w-1:0] c_ctr_y      = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [15:0]        c_delay      = 16'(SERVE_DELAY);
    localparam logic [3:0]         c_win        = 4'(WIN_SCORE);

    state_t             r_state, w_state_nxt;
    logic [15:0]        r_cnt, w_cnt_nxt;
    logic [c_pos_w-1:0] r_x, w_x_nxt, r_y, w_y_nxt;
    logic               r_dx_neg, w_dx_neg_nxt, r_dy_neg, w_dy_neg_nxt;
    logic [3:0]         r_player_score, w_player_score_nxt;
    logic [3:0]         r_ai_score, w_ai_score_nxt;
    logic               r_point_player, w_point_player_nxt;
    logic               r_point_ai, w_point_ai_nxt;
    logic               r_last_ai, w_last_ai_nxt;

    logic signed [10:0] w_dx, w_dy, w_nx, w_ny;
    logic               w_dx_pos, w_left_hit, w_right_hit;
    logic [c_pos_w-1:0] w_step_x, w_step_y;
    logic               w_step_dx_neg, w_step_dy_neg, w_miss_left, w_miss_right;

    assign w_dx     = r_dx_neg ? -c_spd : c_spd;
    assign w_dy     = r_dy_neg ? -c_spd : c_spd;
    assign w_nx     = $signed({1'b0, r_x}) + w_dx;
    assign w_ny     = $signed({1'b0, r_y}) + w_dy;
    assign w_dx_pos = ~r_dx_neg;

    paddle_hit_check #(
        .IS_LEFT   (1'b1),
        .EDGE_X    (LEFT_PADDLE_X + PADDLE_W),
        .BALL_SIZE (BALL_SIZE),
        .PADDLE_H  (PADDLE_H)
    ) u_left_hit (
        .i_ball_x   (r_x),
        .i_ball_y   (r_y),
        .i_next_x   (w_nx),
        .i_toward   (r_dx_neg),
        .i_paddle_y (player_paddle_y),
        .o_hit      (w_left_hit)
    );

    paddle_hit_check #(
        .IS_LEFT   (1'b0),
        .EDGE_X    (RIGHT_PADDLE_X - BALL_SIZE),
        .BALL_SIZE (BALL_SIZE),
        .PADDLE_H  (PADDLE_H)
    ) u_right_hit (
        .i_ball_x   (r_x),
        .i_ball_y   (r_y),
        .i_next_x   (w_nx),
        .i_toward   (w_dx_pos),
        .i_paddle_y (ai_paddle_y),
        .o_hit      (w_right_hit)
    );

    // One frame of motion; the vertical and horizontal responses are independent.
    always_comb begin
        w_step_y      = w_ny[c_pos_w-1:0];
        w_step_dy_neg = r_dy_neg;
        if (w_ny <= 11'sd0) begin
            w_step_y      = '0;
            w_step_dy_neg = 1'b0;
        end else if (w_ny >= c_y_max) begin
            w_step_y      = c_y_max[c_pos_w-1:0];
            w_step_dy_neg = 1'b1;
        end

        w_step_x      = w_nx[c_pos_w-1:0];
        w_step_dx_neg = r_dx_neg;
        w_miss_left   = 1'b0;
        w_miss_right  = 1'b0;
        if (w_left_hit) begin
            w_step_x      = c_left_edge[c_pos_w-1:0];
            w_step_dx_neg = 1'b0;
        end else if (w_right_hit) begin
            w_step_x      = c_right_edge[c_pos_w-1:0];
            w_step_dx_neg = 1'b1;
        end else if (w_nx <= 11'sd0) begin
            w_step_x    = '0;
            w_miss_left = 1'b1;
        end else if (w_nx >= c_x_max) begin
            w_step_x     = c_x_max[c_pos_w-1:0];
            w_miss_right = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_x_nxt            = r_x;
        w_y_nxt            = r_y;
        w_dx_neg_nxt       = r_dx_neg;
        w_dy_neg_nxt       = r_dy_neg;
        w_player_score_nxt = r_player_score;
        w_ai_score_nxt     = r_ai_score;
        w_point_player_nxt = 1'b0;
        w_point_ai_nxt     = 1'b0;
        w_last_ai_nxt      = r_last_ai;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SERVE_WAIT;
                    w_cnt_nxt   = c_delay;
                    if ((r_player_score >= c_win) || (r_ai_score >= c_win)) begin
                        w_player_score_nxt = '0;
                        w_ai_score_nxt     = '0;
                    end
                end
            end
            SERVE_WAIT: begin
                if (frame_tick) begin
                    if (r_cnt == '0) begin
                        // The releasing frame already moves the ball.
                        w_state_nxt  = PLAY;
                        w_x_nxt      = w_step_x;
                        w_y_nxt      = w_step_y;
                        w_dx_neg_nxt = w_step_dx_neg;
                        w_dy_neg_nxt = w_step_dy_neg;
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                    end
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    w_x_nxt      = w_step_x;
                    w_y_nxt      = w_step_y;
                    w_dx_neg_nxt = w_step_dx_neg;
                    w_dy_neg_nxt = w_step_dy_neg;
                    if (w_miss_left) begin
                        w_ai_score_nxt = sat_inc(r_ai_score);
                        w_point_ai_nxt = 1'b1;
                        w_last_ai_nxt  = 1'b1;
                        w_state_nxt    = POINT;
                    end else if (w_miss_right) begin
                        w_player_score_nxt = sat_inc(r_player_score);
                        w_point_player_nxt = 1'b1;
                        w_last_ai_nxt      = 1'b0;
                        w_state_nxt        = POINT;
                    end
                end
            end
            POINT: begin
                // Serve heads toward whoever just conceded.
                w_x_nxt      = c_ctr_x;
                w_y_nxt      = c_ctr_y;
                w_dx_neg_nxt = r_last_ai;
                w_dy_neg_nxt = 1'b0;
                if ((r_player_score == c_win) || (r_ai_score == c_win)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = SERVE_WAIT;
                    w_cnt_nxt   = c_delay;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_x            <= c_ctr_x;
            r_y            <= c_ctr_y;
            r_dx_neg       <= 1'b0;
            r_dy_neg       <= 1'b0;
            r_player_score <= '0;
            r_ai_score     <= '0;
            r_point_player <= 1'b0;
            r_point_ai     <= 1'b0;
            r_last_ai      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_x            <= w_x_nxt;
            r_y            <= w_y_nxt;
            r_dx_neg       <= w_dx_neg_nxt;
            r_dy_neg       <= w_dy_neg_nxt;
            r_player_score <= w_player_score_nxt;
            r_ai_score     <= w_ai_score_nxt;
            r_point_player <= w_point_player_nxt;
            r_point_ai     <= w_point_ai_nxt;
            r_last_ai      <= w_last_ai_nxt;
        end
    end

    assign ball_state   = {r_y, r_x};
    assign player_score = r_player_score;
    assign ai_score     = r_ai_score;
    assign point_player = r_point_player;
    assign point_ai     = r_point_ai;
    assign in_play      = (r_state == PLAY);

endmodule
`default_nettype wire

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 Parameter SCREEN_W, 640, playfield width in pixels.
REQ-002 Parameter SCREEN_H, 480, playfield height in pixels.
REQ-003 Parameter BALL_SIZE, 8, ball square edge in pixels.
REQ-004 Parameter PADDLE_W, 8 and PADDLE_H, 64, paddle dimensions.
REQ-005 Parameter LEFT_PADDLE_X, 16 and RIGHT_PADDLE_X, 616, paddle left-edge x.
REQ-006 Parameter SPEED, 2, per-frame step magnitude on each axis.
REQ-007 Parameter SERVE_DELAY, 60, frames between serve request and motion.
REQ-008 Parameter WIN_SCORE, 9, points ending a game.
REQ-009 One clock and reset: reset is asynchronous and active-high; ports are clk and reset.
REQ-010 clk  in  1  system clock.
REQ-011 reset  in  1  async active-high reset.
REQ-012 frame_tick  in  1  one-cycle pulse per video frame.
REQ-013 start  in  1  one-cycle serve/new-game request.
REQ-014 player_paddle_y  in  10  left paddle top-edge y.
REQ-015 ai_paddle_y  in  10  right paddle top-edge y.
REQ-016 ball_state  out  20  {y[19:10], x[9:0]}, ball top-left corner, registered.
REQ-017 player_score, ai_score  out  4 each  current scores.
REQ-018 point_player, point_ai  out  1 each  one-cycle pulse on a point.
REQ-019 in_play  out  1  high only in PLAY state.

Function
REQ-020 FSM states: IDLE, SERVE_WAIT, PLAY, POINT; all motion updates occur on the clk edge sampling frame_tick high (1-cycle latency).
REQ-021 IDLE: start -> SERVE_WAIT, counter loaded with SERVE_DELAY; if scores reached WIN_SCORE, start also clears both scores.
REQ-022 SERVE_WAIT: counter decrements per frame_tick; frame_tick at counter 0 -> PLAY; start ignored.
REQ-023 PLAY: per frame_tick next position = position + signed velocity, computed in 11-bit signed arithmetic.
REQ-024 Top wall: next y <= 0 -> y=0, dy=+SPEED; bottom: next y >= SCREEN_H-BALL_SIZE -> clamp there, dy=-SPEED.
REQ-025 Left paddle hit: dx<0, x >= LEFT_PADDLE_X+PADDLE_W, next x <= that edge, and y+BALL_SIZE > player_paddle_y and y < player_paddle_y+PADDLE_H -> x=edge, dx=+SPEED.
REQ-026 Right paddle hit: mirror of REQ-025 against RIGHT_PADDLE_X-BALL_SIZE with ai_paddle_y, dx=-SPEED.
REQ-027 Wall and paddle responses in the same frame apply independently (corner hit).
REQ-028 Miss: next x <= 0 -> ai_score+1, point_ai pulse; next x >= SCREEN_W-BALL_SIZE -> player_score+1, point_player pulse; state -> POINT.
REQ-029 POINT (one cycle): ball recentred to ((SCREEN_W-BALL_SIZE)/2, (SCREEN_H-BALL_SIZE)/2), dx toward the conceding side, dy=+SPEED; -> IDLE if either score equals WIN_SCORE, else SERVE_WAIT with counter reloaded.
REQ-030 Scores saturate at 15; paddle inputs sampled only on frame_tick.

Reset
REQ-031 Reset at any time: state IDLE, ball_state {236,316}, dx=+SPEED, dy=+SPEED, scores 0, pulses 0, in_play 0, counter 0.

Structure
REQ-032 Screen/paddle constants and the state enum live in shared package pong_pkg.
REQ-033 One sub-module, paddle_hit_check (combinational overlap/crossing test), instanced twice.

Verification
REQ-034 Reset -> ball_state=={236,316}, scores 0, in_play 0.
REQ-035 start, then 60 frame_ticks -> ball static; 61st frame_tick -> in_play 1, x=318, y=238.
REQ-036 PLAY, y=2, dy=-2, frame_tick -> y=0, dy=+2.
REQ-037 player_paddle_y=200, x=26, y=220, dx=-2, frame_tick -> x=24, dx=+2.
REQ-038 player_paddle_y=0, x=2, y=300, dx=-2, frame_tick -> ai_score=1, one-cycle point_ai, recentred, SERVE_WAIT.
REQ-039 ai_score=8, same miss -> ai_score=9, IDLE, in_play 0; start -> scores 0.
